dm_arbiter: RTL

//  Shares the single-port 32-bit data memory between two requesters: the pipeline
//  MEM stage (core port, c_*) and the program loader/debug port (loader port, l_*).

---
 rtl/dm_arbiter_pkg.sv | 27 ++
 rtl/dm_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dm_arbiter_pkg
//   Shared definitions for the data-memory arbiter slice:
//     - DM_* access-type codes (the same DMType encoding the MEM stage and
//       the data memory use)
//     - default starvation limit for the loader port
//     - arbiter FSM state type
// ----------------------------------------------------------------------------
package dm_arbiter_pkg;

    // Data-memory access types
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    // Loader cycles spent waiting before it is forced a grant
    localparam int DM_ARB_STARVE = 4;

    // Arbiter FSM states
    typedef enum logic {
        ARB_ST_ARB    = 1'b0,
        ARB_ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------------
// dm_arbiter
//   Shares the single-port 32-bit data memory between the pipeline MEM stage
//   (core port, c_*) and the program loader / debug port (loader port, l_*).
//   The core has fixed priority, a wait counter forces a loader grant after
//   STARVE_LIMIT waiting cycles, and l_lock gives the loader burst ownership.
//   Grants and the memory-side mux are combinational; load data is returned
//   registered one cycle after the grant.
//
// Ports
//   clk, rstn                     clock (rising edge), synchronous active-low reset
//   c_req/c_we/c_type/c_addr/c_wdata   core request (held until c_gnt)
//   c_gnt, c_stall                core grant this cycle / pipeline freeze
//   c_rvalid, c_rdata             core load response (1-cycle pulse, registered data)
//   l_req/l_we/l_type/l_addr/l_wdata   loader request (held until l_gnt)
//   l_lock                        loader asks for bus ownership for a burst
//   l_gnt, l_rvalid, l_rdata      loader grant and load response
//   dm_we/dm_type/dm_addr/dm_din  memory command lines
//   dm_dout                       memory read data (combinational read)
// ----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DM_ARB_STARVE,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [2:0]  c_type,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_stall,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,

    input  logic        l_req,
    input  logic        l_we,
    input  logic [2:0]  l_type,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    input  logic        l_lock,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,

    output logic        dm_we,
    output logic [2:0]  dm_type,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             starved;

    assign starved = (wait_cnt == LIMIT);

    // Grant decision and memory-side mux. While locked the loader owns the
    // port even if it is not requesting (an idle locked cycle is a no-op).
    // With no grant the core values stay on the address/data lines so the
    // memory inputs do not toggle needlessly; dm_we is gated off.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rstn) begin
            if (state == ARB_ST_LOCKED) begin
                l_gnt = l_req;
            end else if (starved && l_req) begin
                l_gnt = 1'b1;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end

        if (l_gnt) begin
            dm_type = l_type;
            dm_addr = l_addr;
            dm_din  = l_wdata;
        end else begin
            dm_type = c_type;
            dm_addr = c_addr;
            dm_din  = c_wdata;
        end

        dm_we = (c_gnt & c_we) | (l_gnt & l_we);
    end

    assign c_stall = c_req & ~c_gnt;

    // FSM, loader wait counter and load-response registers.
    // The counter only runs in ARB while the loader is refused; any grant,
    // an idle loader or the locked state clears it. Reaching LIMIT is
    // always followed by a grant, so the saturation guard is a safety net.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ARB_ST_ARB;
            wait_cnt <= '0;
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            c_rdata  <= '0;
            l_rdata  <= '0;
        end else begin
            case (state)
                ARB_ST_ARB: begin
                    if (l_gnt && l_lock) begin
                        state <= ARB_ST_LOCKED;
                    end
                end
                ARB_ST_LOCKED: begin
                    if (!l_lock) begin
                        state <= ARB_ST_ARB;
                    end
                end
                default: state <= ARB_ST_ARB;
            endcase

            if (state == ARB_ST_ARB && l_req && !l_gnt) begin
                if (!starved) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            c_rvalid <= c_gnt & ~c_we;
            l_rvalid <= l_gnt & ~l_we;

            if (c_gnt && !c_we) begin
                c_rdata <= dm_dout;
            end
            if (l_gnt && !l_we) begin
                l_rdata <= dm_dout;
            end
        end
    end

endmodule
